// File: rtl/neuron_accumulator.sv
// Saturating Q8.8 accumulator for one neuron: bias + sum of product terms, optional ReLU.
// Optional feature macro: NEURON_ACC_RELU_EN (clamps negative results to zero).
module neuron_accumulator #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  n_terms,
   input  logic [DATA_W-1:0] bias,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              sat_flag
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

   state_t            state_reg;
   logic [DATA_W-1:0] acc_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              sat_reg;
   logic [DATA_W-1:0] out_data_reg;
   logic              out_valid_reg;
   logic              in_ready_reg;
   logic              busy_reg;

   logic [DATA_W:0]   sum_ext;
   logic              sat_hi;
   logic              sat_lo;
   logic [DATA_W-1:0] acc_next;
   logic              take_term;
   logic              last_term;

   // One extra bit of headroom; disagreement between the top two bits means overflow.
   assign sum_ext = {acc_reg[DATA_W-1], acc_reg} + {in_data[DATA_W-1], in_data};
   assign sat_hi  = ~sum_ext[DATA_W] &  sum_ext[DATA_W-1];
   assign sat_lo  =  sum_ext[DATA_W] & ~sum_ext[DATA_W-1];

   always_comb begin
      acc_next = sum_ext[DATA_W-1:0];
      if (sat_hi) begin
         acc_next = MAX_VAL;
      end else if (sat_lo) begin
         acc_next = MIN_VAL;
      end
   end

   assign take_term = in_valid && in_ready_reg;
   assign last_term = (cnt_reg == CNT_W'(1));

   function automatic logic [DATA_W-1:0] activate(input logic [DATA_W-1:0] v);
`ifdef NEURON_ACC_RELU_EN
      activate = v[DATA_W-1] ? '0 : v;
`else
      activate = v;
`endif
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         sat_reg       <= 1'b0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  acc_reg  <= bias;
                  cnt_reg  <= n_terms;
                  sat_reg  <= 1'b0;
                  busy_reg <= 1'b1;
                  if (n_terms == '0) begin
                     state_reg     <= DONE;
                     out_valid_reg <= 1'b1;
                     out_data_reg  <= activate(bias);
                  end else begin
                     state_reg    <= ACC;
                     in_ready_reg <= 1'b1;
                  end
               end
            end
            ACC: begin
               if (take_term) begin
                  acc_reg <= acc_next;
                  cnt_reg <= cnt_reg - CNT_W'(1);
                  if (sat_hi || sat_lo) begin
                     sat_reg <= 1'b1;
                  end
                  // Output register is loaded together with the final step so
                  // out_data is already stable when out_valid rises.
                  if (last_term) begin
                     state_reg     <= DONE;
                     in_ready_reg  <= 1'b0;
                     out_valid_reg <= 1'b1;
                     out_data_reg  <= activate(acc_next);
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
               end
            end
            default: begin
               state_reg     <= IDLE;
               in_ready_reg  <= 1'b0;
               out_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign busy      = busy_reg;
   assign sat_flag  = sat_reg;

endmodule
